// File: rtl/control_rtc_if.sv
// rtl/control_rtc_if.sv - processor-side and RTC control signals of control_rtc
`timescale 1ns/1ps

interface control_rtc_if;
  logic       actRTC;
  logic       writestrobe;
  logic       read_strobe;
  logic [7:0] dir;
  logic [7:0] out_port;
  logic [7:0] in_portRTC;
  logic       busy;
  logic       done;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic       A_D;

  modport master (
    output actRTC, writestrobe, read_strobe, dir, out_port,
    input  in_portRTC, busy, done, CS_n, RD_n, WR_n, A_D
  );

  modport slave (
    input  actRTC, writestrobe, read_strobe, dir, out_port,
    output in_portRTC, busy, done, CS_n, RD_n, WR_n, A_D
  );
endinterface

// File: rtl/control_rtc.sv
// rtl/control_rtc.sv - PicoBlaze to RTC multiplexed address/data bus controller (option macro RTC_STATUS_EN)
`timescale 1ns/1ps

module control_rtc #(
  parameter int N_PULSE = 10,
  parameter int N_GAP   = 4
) (
  input  logic         clk,
  input  logic         reset,
  control_rtc_if.slave bus,
  inout  wire  [7:0]   AD
);

  // Counter must hold the longest state duration and is never narrower than 8 bits.
  localparam int MAXD = (N_PULSE > N_GAP) ? N_PULSE : N_GAP;
  localparam int CW   = ($clog2(MAXD) > 8) ? $clog2(MAXD) : 8;
  localparam logic [CW-1:0] PULSE_LD = CW'(N_PULSE - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(N_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_SETUP,
    S_ADDR_PULSE,
    S_GAP,
    S_DATA_SETUP,
    S_DATA_PULSE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    addr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    data_q;
  logic          wr_q;

  logic          launch_wr;
  logic          launch_rd;
  logic          launch;
  logic          cnt_last;
  logic          sample_rd;
  logic          busy_w;

  logic          cs_n_w;
  logic          rd_n_w;
  logic          wr_n_w;
  logic          a_d_w;
  logic          ad_oe;
  logic [7:0]    ad_out;

`ifdef RTC_STATUS_EN
  // Address 0xFF is the controller's own status port: reads there never reach the chip.
  logic status_sel;
  assign status_sel = (bus.dir == 8'hFF);
  assign launch_rd  = bus.actRTC & bus.read_strobe & ~status_sel;
`else
  assign launch_rd  = bus.actRTC & bus.read_strobe;
`endif

  // Write has priority when both strobes arrive together; strobes outside IDLE are dropped.
  assign launch_wr = bus.actRTC & bus.writestrobe;
  assign launch    = (state_q == S_IDLE) & (launch_wr | launch_rd);
  assign cnt_last  = (cnt_q == '0);
  assign sample_rd = (state_q == S_DATA_PULSE) & ~wr_q & cnt_last;
  assign busy_w    = (state_q != S_IDLE);

  // State and cycle counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: each state counts down from (duration-1); the counter is reloaded on every entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
      if (launch) begin
        state_d = S_ADDR_SETUP;
      end
    end else if (!cnt_last) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      case (state_q)
        S_ADDR_SETUP: begin
          state_d = S_ADDR_PULSE;
          cnt_d   = PULSE_LD;
        end
        S_ADDR_PULSE: begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end
        S_GAP: begin
          state_d = S_DATA_SETUP;
          cnt_d   = '0;
        end
        S_DATA_SETUP: begin
          state_d = S_DATA_PULSE;
          cnt_d   = PULSE_LD;
        end
        S_DATA_PULSE: begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Transaction context is frozen at launch; read data is captured on the last strobe cycle only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      wr_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      if (launch) begin
        addr_q  <= bus.dir;
        wdata_q <= bus.out_port;
        wr_q    <= launch_wr;
      end
      if (sample_rd) begin
        data_q <= AD;
      end
    end
  end

  // Bus pin decode straight from state, so an asynchronous reset releases the bus immediately.
  always_comb begin
    cs_n_w = 1'b1;
    rd_n_w = 1'b1;
    wr_n_w = 1'b1;
    a_d_w  = 1'b0;
    ad_oe  = 1'b0;
    ad_out = 8'h00;
    case (state_q)
      S_ADDR_SETUP, S_GAP: begin
        cs_n_w = 1'b0;
        a_d_w  = 1'b1;
        ad_oe  = 1'b1;
        ad_out = addr_q;
      end
      S_ADDR_PULSE: begin
        cs_n_w = 1'b0;
        wr_n_w = 1'b0;
        a_d_w  = 1'b1;
        ad_oe  = 1'b1;
        ad_out = addr_q;
      end
      S_DATA_SETUP: begin
        cs_n_w = 1'b0;
        ad_oe  = wr_q;
        ad_out = wdata_q;
      end
      S_DATA_PULSE: begin
        cs_n_w = 1'b0;
        wr_n_w = ~wr_q;
        rd_n_w = wr_q;
        ad_oe  = wr_q;
        ad_out = wdata_q;
      end
      default: begin
        cs_n_w = 1'b1;
      end
    endcase
  end

  assign AD       = ad_oe ? ad_out : 8'hzz;
  assign bus.CS_n = cs_n_w;
  assign bus.RD_n = rd_n_w;
  assign bus.WR_n = wr_n_w;
  assign bus.A_D  = a_d_w;
  assign bus.busy = busy_w;
  assign bus.done = (state_q == S_DONE);

`ifdef RTC_STATUS_EN
  assign bus.in_portRTC = (bus.actRTC && status_sel) ? {7'b0, busy_w} : data_q;
`else
  assign bus.in_portRTC = data_q;
`endif

endmodule

// File: doc/control_rtc.md
CONTROL_RTC -- requirements
Module: control_rtc

Interface
REQ-001 Parameter N_PULSE, default 10: clock cycles each WR_n/RD_n strobe is held low (100 ns at 100 MHz).
REQ-002 Parameter N_GAP, default 4: clock cycles between the address phase and the data phase.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 actRTC  input  1  RTC port-decode select from the PicoBlaze wrapper.
REQ-006 writestrobe  input  1  one-cycle write strobe from the processor.
REQ-007 read_strobe  input  1  one-cycle read strobe from the processor.
REQ-008 dir  input  8  RTC register address.
REQ-009 out_port  input  8  write data.
REQ-010 in_portRTC  output  8  read data returned to the processor input mux.
REQ-011 busy  output  1  high while a bus transaction is in progress.
REQ-012 done  output  1  one-cycle pulse at transaction end.
REQ-013 AD  inout  8  multiplexed address/data bus to the RTC chip.
REQ-014 CS_n, RD_n, WR_n, A_D  output  1 each  chip select, read strobe, write strobe (all active-low), and address/data select (1 = address).

Function
REQ-015 In IDLE, actRTC&writestrobe launches a write; actRTC&read_strobe launches a read; if both strobes are high together, the write wins.
REQ-016 On launch, dir and out_port are latched into internal registers; later input changes do not affect the transaction.
REQ-017 Strobes arriving while busy=1 are ignored, with no queueing.
REQ-018 States and durations: IDLE -> ADDR_SETUP (1) -> ADDR_PULSE (N_PULSE) -> GAP (N_GAP) -> DATA_SETUP (1) -> DATA_PULSE (N_PULSE) -> DONE (1) -> IDLE.
REQ-019 busy = (state != IDLE); busy is high for exactly 3+2*N_PULSE+N_GAP cycles (27 at defaults), starting the cycle after launch.
REQ-020 CS_n is low from ADDR_SETUP through DATA_PULSE and high in IDLE and DONE.
REQ-021 A_D is 1 in ADDR_SETUP, ADDR_PULSE and GAP, and 0 in all other states.
REQ-022 AD is driven with latched dir in ADDR_SETUP, ADDR_PULSE and GAP.
REQ-023 For a write, AD is driven with latched out_port in DATA_SETUP and DATA_PULSE.
REQ-024 AD is high-Z in IDLE and DONE, and during the read data phase.
REQ-025 WR_n is low during ADDR_PULSE for every transaction, and during DATA_PULSE for writes only.
REQ-026 RD_n is low during DATA_PULSE for reads only.
REQ-027 A read samples AD into data_reg on the last cycle of DATA_PULSE; data_reg updates only then.
REQ-028 in_portRTC = data_reg; the INPUT that launches a read returns the previous read result (firmware: launch, poll busy, INPUT again).
REQ-029 done is high only in DONE.
REQ-030 The internal cycle counter is at least 8 bits, is reloaded on every state entry, and never wraps within a state.

Reset
REQ-031 Reset asserted at any time, including mid-transaction, takes effect immediately:
- state IDLE; CS_n, RD_n, WR_n = 1; A_D = 0; AD high-Z.
- busy = 0, done = 0, data_reg = 0x00, counter = 0.
REQ-032 A transaction in progress when reset asserts is abandoned and is not resumed after reset deasserts.

Configuration
REQ-033 Macro RTC_STATUS_EN:
- Defined: when actRTC=1 and dir=0xFF, in_portRTC is combinationally {7'b0,busy}, and a read_strobe at dir 0xFF launches no bus cycle; writes to 0xFF still launch normally.
- Undefined: 0xFF is an ordinary RTC address and in_portRTC is always data_reg.

Verification (N_PULSE=10, N_GAP=4)
REQ-034 Write: dir=0x21, out_port=0x45, one-cycle writestrobe with actRTC -> AD=0x21, A_D=1, WR_n low 10 cycles; then after the gap AD=0x45, A_D=0, WR_n low 10 cycles; busy high 27 cycles; done pulses once.
REQ-035 Read: RTC model drives 0x59 while RD_n is low, dir=0x22, read_strobe -> address phase carries 0x22, RD_n low 10 cycles, in_portRTC=0x59 from the DONE cycle onward.
REQ-036 writestrobe pulsed at busy cycle 5, and writestrobe and read_strobe asserted together in IDLE -> the first is ignored with no extra bus activity; the second runs a write.
REQ-037 Reset asserted in the 3rd cycle of the write DATA_PULSE -> in the same cycle WR_n=CS_n=1, AD high-Z, busy=0, in_portRTC=0x00; no activity after release until a new strobe.
REQ-038 With RTC_STATUS_EN: during a write, actRTC with dir=0xFF -> in_portRTC=0x01; read_strobe at 0xFF causes no CS_n activity; once idle, in_portRTC=0x00.
